udb_clock_enable_gen: RTL

- Generates a programmable, periodic single-cycle enable strobe from a fast UDB clock.
- The strobe is the `enable` input consumed downstream by the UDB clock-enable primitive, which gates the clock. This block is the producer end of that enable path.
- Divider changes use a load/acknowledge handshake and take effect only at a period boundary, so the strobe never produces a runt or stretched period.

---
 rtl/udb_clock_enable_gen_if.sv | 23 ++
 rtl/udb_clock_enable_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/udb_clock_enable_gen_if.sv
// Control/status bundle for udb_clock_enable_gen: run level and divider
// load handshake towards the generator, enable strobe and status back.
interface udb_clock_enable_gen_if #(
  parameter int Width = 8
) ();
  logic             run;
  logic [Width-1:0] div_value;
  logic             div_load;
  logic             div_ack;
  logic             en_out;
  logic             running;
  logic             pending;

  modport master (
    output run, div_value, div_load,
    input  div_ack, en_out, running, pending
  );

  modport slave (
    input  run, div_value, div_load,
    output div_ack, en_out, running, pending
  );
endinterface

// File: rtl/udb_clock_enable_gen.sv
// Periodic single-cycle enable strobe (period = divider + 1) with a
// boundary-aligned divider load/ack handshake. Define
// UDB_CLOCK_ENABLE_GEN_SYNC_EN to pass run through a 2-flop synchronizer.
module udb_clock_enable_gen #(
  parameter int Width        = 8,
  parameter int ResetDivider = 0
) (
  input logic                   clock,
  input logic                   reset,
  udb_clock_enable_gen_if.slave bus
);

  localparam logic [Width-1:0] ResetDiv = Width'(ResetDivider);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [Width-1:0] count;
  logic [Width-1:0] div_active;
  logic [Width-1:0] div_pend;
  logic             pending_q;
  logic             en_q;
  logic             ack_q;
  logic             running_q;
  logic             run_q;
  logic             apply;
  logic [Width-1:0] div_active_next;

`ifdef UDB_CLOCK_ENABLE_GEN_SYNC_EN
  logic run_meta;
  logic run_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= bus.run;
      run_sync <= run_meta;
    end
  end

  assign run_q = run_sync;
`else
  assign run_q = bus.run;
`endif

  // Count is held at zero in IDLE, so one test covers both apply points.
  assign apply           = pending_q && ((state == IDLE) || (count == '0));
  assign div_active_next = apply ? div_pend : div_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      div_active <= ResetDiv;
      div_pend   <= '0;
      pending_q  <= 1'b0;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      if (bus.div_load) begin
        div_pend <= bus.div_value;
      end
      // A load on the apply edge re-arms pending with the newer value.
      pending_q  <= bus.div_load | (pending_q & ~apply);
      ack_q      <= apply;
      div_active <= div_active_next;

      case (state)
        IDLE: begin
          en_q <= 1'b0;
          if (run_q) begin
            state     <= RUN;
            count     <= div_active_next;
            running_q <= 1'b1;
          end else begin
            count     <= '0;
            running_q <= 1'b0;
          end
        end
        RUN: begin
          if (!run_q) begin
            state     <= IDLE;
            count     <= '0;
            en_q      <= 1'b0;
            running_q <= 1'b0;
          end else begin
            en_q      <= (count == '0);
            count     <= (count == '0) ? div_active_next : count - 1'b1;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          en_q      <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_out  = en_q;
  assign bus.div_ack = ack_q;
  assign bus.running = running_q;
  assign bus.pending = pending_q;

endmodule
